// File: rtl/fetch_ifid_stage.sv
// fetch_ifid_stage: PC owner and IF/ID pipeline register with stall, flush, wait-state and HLT handling.
module fetch_ifid_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] branch_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_rdy,
    output logic [15:0] pc,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus2,
    output logic        if_id_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);
    typedef enum logic {FETCH, HALTED} state_t;
    state_t state, state_d;
    logic [15:0] pc_d, instr_d, pp2_d, cnt_d, pc_plus2;
    logic        valid_d;
    assign pc_plus2  = pc + 16'd2;
    assign imem_addr = pc;
    assign halted    = state == HALTED;
    always_comb begin
        state_d = state;
        pc_d    = pc;
        instr_d = if_id_instr;
        pp2_d   = if_id_pc_plus2;
        valid_d = if_id_valid;
        cnt_d   = fetch_count;
        if (flush) begin
            state_d = FETCH;
            pc_d    = branch_target;
            instr_d = NOP_INSTR;
            pp2_d   = 16'h0000;
            valid_d = 1'b0;
        end else if (!stall) begin
            // Halted or waiting on I-mem: inject a bubble and keep the PC.
            if (state == HALTED || !imem_rdy) begin
                instr_d = NOP_INSTR;
                pp2_d   = 16'h0000;
                valid_d = 1'b0;
            end else begin
                instr_d = imem_data;
                pp2_d   = pc_plus2;
                valid_d = 1'b1;
                cnt_d   = fetch_count + 16'd1;
                state_d = imem_data[15:12] == 4'hF ? HALTED : FETCH;
                pc_d    = imem_data[15:12] == 4'hF ? pc : pc_plus2;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus2 <= 16'h0000;
            if_id_valid    <= 1'b0;
            fetch_count    <= 16'h0000;
        end else begin
            state          <= state_d;
            pc             <= pc_d;
            if_id_instr    <= instr_d;
            if_id_pc_plus2 <= pp2_d;
            if_id_valid    <= valid_d;
            fetch_count    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fetch_ifid_stage.sv
// tb_fetch_ifid_stage: directed vectors feed a scoreboard queue; a monitor checks state after each edge.
module tb_fetch_ifid_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1, stall = 1'b0, flush = 1'b0, imem_rdy = 1'b0;
    logic [15:0] branch_target = 16'h0000, imem_data = 16'h0000;
    logic [15:0] imem_addr, pc, if_id_instr, if_id_pc_plus2, fetch_count;
    logic        if_id_valid, halted;
    int          checks = 0, errors = 0;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [15:0] instr;
        int          pp2;
        logic        valid;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;
    exp_t q[$];

    fetch_ifid_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_data(imem_data), .imem_rdy(imem_rdy), .pc(pc),
        .if_id_instr(if_id_instr), .if_id_pc_plus2(if_id_pc_plus2), .if_id_valid(if_id_valid),
        .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "pc", pc, e.pc);
            chk(e.name, "imem_addr", imem_addr, e.pc);
            chk(e.name, "instr", if_id_instr, e.instr);
            if (e.pp2 >= 0) chk(e.name, "pc_plus2", if_id_pc_plus2, e.pp2[15:0]);
            chk(e.name, "valid", {15'd0, if_id_valid}, {15'd0, e.valid});
            chk(e.name, "halted", {15'd0, halted}, {15'd0, e.halted});
            chk(e.name, "count", fetch_count, e.cnt);
        end
    end

    task automatic step(input string nm, input logic r, s, f, input logic [15:0] bt,
                        input logic rdy, input logic [15:0] d,
                        input logic [15:0] epc, ei, input int epp,
                        input logic ev, eh, input logic [15:0] ec);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; flush = f; branch_target = bt; imem_rdy = rdy; imem_data = d;
        e.name = nm; e.pc = epc; e.instr = ei; e.pp2 = epp;
        e.valid = ev; e.halted = eh; e.cnt = ec;
        q.push_back(e);
    endtask

    initial begin
        //    name          rst stl fl  target    rdy data      pc        instr     pp2      v  h  cnt
        step("reset",       1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h4000, 0,      0, 0, 16'd0);
        step("fetch_a",     0, 0, 0, 16'h0000, 1, 16'h1111, 16'h0002, 16'h1111, 'h2,    1, 0, 16'd1);
        step("fetch_b",     0, 0, 0, 16'h0000, 1, 16'h2222, 16'h0004, 16'h2222, 'h4,    1, 0, 16'd2);
        step("fetch_c",     0, 0, 0, 16'h0000, 1, 16'h3333, 16'h0006, 16'h3333, 'h6,    1, 0, 16'd3);
        step("stall1",      0, 1, 0, 16'h0000, 1, 16'h5555, 16'h0006, 16'h3333, 'h6,    1, 0, 16'd3);
        step("stall2",      0, 1, 0, 16'h0000, 1, 16'h5555, 16'h0006, 16'h3333, 'h6,    1, 0, 16'd3);
        step("resume",      0, 0, 0, 16'h0000, 1, 16'h1234, 16'h0008, 16'h1234, 'h8,    1, 0, 16'd4);
        step("flush_stall", 0, 1, 1, 16'h0040, 1, 16'h5678, 16'h0040, 16'h4000, 0,      0, 0, 16'd4);
        step("wait1",       0, 0, 0, 16'h0000, 0, 16'h7777, 16'h0040, 16'h4000, -1,     0, 0, 16'd4);
        step("wait2",       0, 0, 0, 16'h0000, 0, 16'h7777, 16'h0040, 16'h4000, -1,     0, 0, 16'd4);
        step("wait3",       0, 0, 0, 16'h0000, 0, 16'h7777, 16'h0040, 16'h4000, -1,     0, 0, 16'd4);
        step("after_wait",  0, 0, 0, 16'h0000, 1, 16'hA001, 16'h0042, 16'hA001, 'h42,   1, 0, 16'd5);
        step("flush_hlt",   0, 0, 1, 16'h0010, 1, 16'hF000, 16'h0010, 16'h4000, 0,      0, 0, 16'd5);
        step("hlt",         0, 0, 0, 16'h0000, 1, 16'hF000, 16'h0010, 16'hF000, 'h12,   1, 1, 16'd6);
        step("halt_stall",  0, 1, 0, 16'h0000, 1, 16'h1111, 16'h0010, 16'hF000, 'h12,   1, 1, 16'd6);
        step("halt_nop1",   0, 0, 0, 16'h0000, 1, 16'h1111, 16'h0010, 16'h4000, -1,     0, 1, 16'd6);
        step("halt_nop2",   0, 0, 0, 16'h0000, 1, 16'h2222, 16'h0010, 16'h4000, -1,     0, 1, 16'd6);
        step("halt_flush",  0, 0, 1, 16'h0020, 1, 16'h2222, 16'h0020, 16'h4000, 0,      0, 0, 16'd6);
        step("reset2",      1, 0, 0, 16'h0000, 1, 16'h2222, 16'h0000, 16'h4000, 0,      0, 0, 16'd0);
        step("to_fffe",     0, 0, 1, 16'hFFFE, 1, 16'h2222, 16'hFFFE, 16'h4000, 0,      0, 0, 16'd0);
        step("wrap",        0, 0, 0, 16'h0000, 1, 16'h0123, 16'h0000, 16'h0123, 'h0,    1, 0, 16'd1);
        step("reset3",      1, 0, 0, 16'h0000, 1, 16'hF000, 16'h0000, 16'h4000, 0,      0, 0, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
